// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage and dmem_responder.
// The master drives requests; the slave returns ready, read data and buffer occupancy.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  wb_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, wb_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, wb_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port 16-bit data memory with a 2-entry posted write buffer, read forwarding
// and a fixed read latency; drains buffered writes only in idle, handshake-free cycles.
module dmem_responder #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_responder_if.slave   bus
);
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    logic [0:0]        r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_raddr;
    logic [15:0]       r_rsp_data;
    logic [1:0]        r_wb_cnt;
    logic [ADDR_W-1:0] r_wb_addr [2];
    logic [15:0]       r_wb_data [2];
    logic [15:0]       r_mem     [DEPTH];

    logic [ADDR_W-1:0] w_req_addr;
    logic              w_final;
    logic              w_ready;
    logic              w_hs;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_drain;
    logic [15:0]       w_fwd_data;
    logic              w_unused_addr_hi;

    assign w_req_addr       = bus.req_addr[ADDR_W-1:0];
    assign w_unused_addr_hi = ^bus.req_addr[15:ADDR_W];

    assign w_final  = (r_state == S_READ) && (r_cnt == 3'd0);
    assign w_ready  = ((r_state == S_IDLE) || w_final) && (r_wb_cnt != 2'd2);
    assign w_hs     = bus.req_valid && w_ready;
    assign w_rd_acc = w_hs && !bus.req_write;
    assign w_wr_acc = w_hs && bus.req_write;
    // The array port is free only when idle and no new request is taken.
    assign w_drain  = (r_state == S_IDLE) && !w_hs && (r_wb_cnt != 2'd0);

    // Slot 1 is always younger than slot 0, so it is checked first.
    always_comb begin
        w_fwd_data = r_mem[r_raddr];
        if ((r_wb_cnt == 2'd2) && (r_wb_addr[1] == r_raddr)) begin
            w_fwd_data = r_wb_data[1];
        end else if ((r_wb_cnt != 2'd0) && (r_wb_addr[0] == r_raddr)) begin
            w_fwd_data = r_wb_data[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_rsp_data <= 16'h0000;
            r_wb_cnt   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_acc) begin
                        r_state <= S_READ;
                        r_cnt   <= LAT_M1;
                    end
                end
                S_READ: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_rsp_data <= w_fwd_data;
                        if (w_rd_acc) begin
                            r_cnt <= LAT_M1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase

            if (w_wr_acc) begin
                r_wb_cnt <= r_wb_cnt + 2'd1;
            end else if (w_drain) begin
                r_wb_cnt <= r_wb_cnt - 2'd1;
            end
        end
    end

    // Data path: not reset; validity is tracked by the control registers above.
    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_raddr <= w_req_addr;
        end
        if (w_wr_acc) begin
            if (r_wb_cnt == 2'd0) begin
                r_wb_addr[0] <= w_req_addr;
                r_wb_data[0] <= bus.req_wdata;
            end else begin
                r_wb_addr[1] <= w_req_addr;
                r_wb_data[1] <= bus.req_wdata;
            end
        end else if (w_drain) begin
            r_mem[r_wb_addr[0]] <= r_wb_data[0];
            r_wb_addr[0]        <= r_wb_addr[1];
            r_wb_data[0]        <= r_wb_data[1];
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_final;
    assign bus.rsp_data  = w_final ? w_fwd_data : r_rsp_data;
    assign bus.wb_count  = r_wb_cnt;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a flat memory model predicts read data at
// acceptance time and a monitor pops expectations whenever a response appears.
module tb_dmem_responder;
    localparam int ADDR_W   = 8;
    localparam int READ_LAT = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
        logic [15:0] addr;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [15:0] model   [1 << ADDR_W];
    bit          written [1 << ADDR_W];
    logic [15:0] last_rsp = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_rsp = 16'h0000;
        end else begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL spurious_rsp: got rsp_valid=1 data %h expected no response (cycle %0d)",
                             bus.rsp_data, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("rsp_data@%h", mon_e.addr), bus.rsp_data, mon_e.data);
                    chk($sformatf("rsp_cycle@%h", mon_e.addr), cyc, mon_e.due);
                end
            end else begin
                chk("rsp_hold", bus.rsp_data, last_rsp);
            end
            last_rsp = bus.rsp_data;
            if (bus.req_ready) chk("ready_while_full", bus.wb_count, (bus.wb_count == 2'd2) ? 2'd1 : bus.wb_count);
        end
    end

    task automatic send(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input bit track, output int acc);
        bit          got;
        logic [15:0] a_loc;
        exp_t        e;
        got   = 1'b0;
        a_loc = a;
        acc   = -1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!got) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            acc = cyc;
            if (track) begin
                if (wr) begin
                    model[a_loc[ADDR_W-1:0]]   = d;
                    written[a_loc[ADDR_W-1:0]] = 1'b1;
                end else begin
                    e.data = model[a_loc[ADDR_W-1:0]];
                    e.due  = cyc + READ_LAT - 1;
                    e.addr = a;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.wb_count == 2'd0 && bus.req_ready && !bus.rsp_valid) ok = 1'b1;
        end
        chk("drain_done", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 16'h0000);
        chk("rst_wb_count", bus.wb_count, 0);
    endtask

    task automatic pulse_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_state();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          a0, a1, a2;
        logic [7:0]  lo [16];
        logic [15:0] ra;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_state();
        @(posedge clk);
        #1;

        // Read-after-write forwarded from the buffer, back to back.
        send(1'b1, 16'h0010, 16'hBEEF, 1'b1, a0);
        send(1'b0, 16'h0010, 16'h0000, 1'b1, a1);
        chk("raw_b2b_accept", a1, a0 + 1);
        wait_drain();

        // Youngest buffered write wins, before and after draining.
        send(1'b1, 16'h0005, 16'h1111, 1'b1, a0);
        send(1'b1, 16'h0005, 16'h2222, 1'b1, a0);
        send(1'b0, 16'h0005, 16'h0000, 1'b1, a0);
        wait_drain();
        send(1'b0, 16'h0005, 16'h0000, 1'b1, a0);
        wait_drain();

        // Back-pressure with a full buffer; same address exposes drain order.
        send(1'b1, 16'h0020, 16'hAAAA, 1'b1, a0);
        send(1'b1, 16'h0020, 16'hBBBB, 1'b1, a1);
        chk("bp_wb_full", bus.wb_count, 2);
        chk("bp_ready_low", bus.req_ready, 0);
        send(1'b1, 16'h0020, 16'hCCCC, 1'b1, a2);
        chk("bp_B_accept", a1, a0 + 1);
        chk("bp_C_accept", a2, a0 + 3);
        chk("bp_wb_after_C", bus.wb_count, 2);
        wait_drain();
        send(1'b0, 16'h0020, 16'h0000, 1'b1, a0);
        wait_drain();

        // Upper address bits alias onto the same word.
        send(1'b1, 16'h1234, 16'hA5A5, 1'b1, a0);
        send(1'b0, 16'h0034, 16'h0000, 1'b1, a0);
        wait_drain();

        // Reset discards a buffered write and an in-flight read.
        send(1'b1, 16'h0007, 16'h0001, 1'b1, a0);
        wait_drain();
        send(1'b1, 16'h0007, 16'h00FF, 1'b0, a0);
        reset_n = 1'b0;
        pulse_reset(2);
        send(1'b0, 16'h0007, 16'h0000, 1'b0, a0);
        reset_n = 1'b0;
        pulse_reset(2);
        send(1'b0, 16'h0007, 16'h0000, 1'b1, a0);
        chk("post_rst_expect", model[7], 16'h0001);
        wait_drain();

        // Randomized mix over a set of low addresses with random aliasing.
        for (int i = 0; i < 16; i++) begin
            lo[i] = 8'(i * 16 + 3);
            send(1'b1, {8'h00, lo[i]}, 16'($urandom), 1'b1, a0);
        end
        for (int n = 0; n < 300; n++) begin
            int idx;
            idx = $urandom_range(0, 15);
            ra  = {8'($urandom_range(0, 255)), lo[idx]};
            if ($urandom_range(0, 1) == 1)
                send(1'b1, ra, 16'($urandom), 1'b1, a0);
            else
                send(1'b0, ra, 16'h0000, 1'b1, a0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        repeat (READ_LAT + 3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's memory-access stage. It accepts single-word read and write requests over a valid/ready handshake and serves them from a single-port 16-bit data array. Writes are posted into a 2-entry write buffer with read forwarding, and reads return after a configurable latency. It replaces the zero-latency combinational data memory so that the pipeline can stall on `req_ready`.

## Interface
- `ADDR_W`, default 8: array depth is 2^ADDR_W 16-bit words; legal range 4..12.
- `READ_LAT`, default 2: cycles from read acceptance to response; legal range 1..7.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_write`  in  1  1 = write, 0 = read; qualified by `req_valid`.
- `req_addr`  in  16  word address; only bits [ADDR_W-1:0] are used, upper bits are ignored (aliasing).
- `req_wdata`  in  16  write data.
- `req_ready`  out  1  request accepted on a rising edge where `req_valid && req_ready`.
- `rsp_valid`  out  1  read data valid; single-cycle pulse.
- `rsp_data`  out  16  read data; holds its last value when `rsp_valid` = 0.
- `wb_count`  out  2  write-buffer occupancy, 0..2.

## Operation
- FSM has two states, IDLE and READ, plus a latency counter `cnt` (3 bits).
- Ready rule: `req_ready` = (IDLE or (READ and `cnt`==0)) and `wb_count` < 2. It never depends on `req_write`.
- Write accept: the entry {addr[ADDR_W-1:0], wdata} is pushed at the tail of the FIFO write buffer. The FSM stays in (or returns to) IDLE.
- Read accept: the FSM goes to READ with `cnt` = READ_LAT-1. The latched address is held until the response.
- READ with `cnt` > 0: decrement `cnt`; `rsp_valid` = 0.
- READ with `cnt` == 0 (final cycle): `rsp_valid` = 1.
  - `rsp_data` = youngest write-buffer entry whose address matches; if none matches, the combinational array read of the latched address.
  - The registered `rsp_data` takes this value.
  - The next state is READ again if a new read is accepted in the same cycle, otherwise IDLE.
- Drain: the array is single-ported. The oldest buffer entry is written to the array at the rising edge ending a cycle in which all of the following hold:
  - state is IDLE;
  - no handshake occurs;
  - `wb_count` > 0.
- Drain and push never coincide, because a push requires a handshake. `wb_count` increments on a push and decrements on a drain.
- Write ordering to the array is FIFO. Two writes to the same address land in request order.
- Read-after-write is always coherent: the youngest buffered write to the address wins over the array and over older buffered entries.
- The array is not reset. Its contents after power-up are undefined.

## Timing
- Reset (`reset_n` low, asynchronous) forces these values:
  - state IDLE, `cnt` = 0;
  - `rsp_valid` = 0, `rsp_data` = 0x0000;
  - write buffer emptied and `wb_count` = 0; pending writes are discarded.
- After reset `req_ready` = 1.
- A read accepted at edge T gives `rsp_valid` high for exactly the cycle after edge T+READ_LAT-1, i.e. READ_LAT cycles after acceptance.
- Read throughput is one read per READ_LAT cycles. With READ_LAT = 1, back-to-back reads run at one per cycle.
- A write accepted at edge T is resident from cycle T+1. It drains at the earliest qualifying edge, and the array holds it from the cycle after the drain.
- Reads observe all accepted writes immediately, regardless of drain state.
- Full buffer: `req_ready` = 0 in that cycle. Because there is no handshake, a drain occurs at the end of that cycle, and `req_ready` returns to 1 in the next cycle.
- Reset mid-read: the response is lost and `rsp_valid` never pulses for that read.

## Test plan
- Reset: hold `reset_n` low, then release. Required: `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0x0000, `wb_count` = 0.
- RAW forwarding (READ_LAT = 2): write 0x0010 ← 0xBEEF, then read 0x0010 in the next cycle. Required: `rsp_valid` pulses exactly 2 cycles after the read handshake, with `rsp_data` = 0xBEEF.
- Youngest wins: write 0x0005 ← 0x1111, write 0x0005 ← 0x2222, then read 0x0005. Required: 0x2222, both before and after the buffer has fully drained (`wb_count` = 0).
- Back-pressure: hold `req_valid`/`req_write` high for three writes (A, B, C) from cycle T. Required:
  - A and B are accepted at T and T+1, and `wb_count` = 2;
  - `req_ready` = 0 in cycle T+2 and a drain occurs; `wb_count` = 1;
  - C is accepted at T+3;
  - the array receives A, B, C in order.
- Aliasing (ADDR_W = 8): write 0x1234 ← 0xA5A5, then read 0x0034. Required: 0xA5A5.
- Reset mid-operation: write 0x0007 ← 0x0001 and let it drain. Then:
  - write 0x0007 ← 0x00FF and assert reset before the drain;
  - separately, assert reset during a READ;
  - after reset, read 0x0007.
  - Required: the read issued before the reset produces no `rsp_valid` pulse, and the read after reset returns 0x0001.
